rgb_col_streamer: RTL and testbench

- Transmit side of the conv-layer column-input interface. It reads an RGB image of IMG_W x IMG_H pixels from three channel memories and streams 3-pixel vertical columns (rows r, r+1, r+2) into rgb_conv_layer_64 as input_col_r/g/b.
- Before the stream it issues the load_weight phase. It walks bands r = 0..IMG_H-3 and columns c = 0..IMG_W-1, and raises done after the last beat is accepted.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/rgb_col_streamer_if.sv | 25 ++
 rtl/rgb_col_streamer_skid.sv | 55 +++++
 rtl/rgb_col_streamer.sv | 168 ++++++++++++++++
 tb/tb_rgb_col_streamer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants, streamer state encoding and column packing for the conv-layer input path.
package conv_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_W     = 18;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_PRIME  = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef struct packed {
        logic [3*DEF_DATA_WIDTH-1:0] r;
        logic [3*DEF_DATA_WIDTH-1:0] g;
        logic [3*DEF_DATA_WIDTH-1:0] b;
    } col_beat_t;

    // Row r lands in the MSBs so the conv layer sees the top pixel first.
    function automatic logic [3*DEF_DATA_WIDTH-1:0] pack_col(
        input logic [DEF_DATA_WIDTH-1:0] row0,
        input logic [DEF_DATA_WIDTH-1:0] row1,
        input logic [DEF_DATA_WIDTH-1:0] row2
    );
        return {row0, row1, row2};
    endfunction

endpackage

// File: rtl/rgb_col_streamer_if.sv
// Column stream from the streamer to rgb_conv_layer_64, plus the weight-load strobe.
interface rgb_col_streamer_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    // A beat moves on a rising edge where input_valid && out_ready; while input_valid
    // is high and out_ready low, input_valid and input_col_* hold their values.
    logic                      load_weight;
    logic [3*DATA_WIDTH-1:0]   input_col_r;
    logic [3*DATA_WIDTH-1:0]   input_col_g;
    logic [3*DATA_WIDTH-1:0]   input_col_b;
    logic                      input_valid;
    logic                      out_ready;

    modport master (
        output load_weight, input_col_r, input_col_g, input_col_b, input_valid,
        input  out_ready
    );

    modport slave (
        input  load_weight, input_col_r, input_col_g, input_col_b, input_valid,
        output out_ready
    );
endinterface

// File: rtl/rgb_col_streamer_skid.sv
// Two-entry valid/ready buffer that absorbs the memory read latency under backpressure.
module col_skid_buf #(
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       level
);
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;

    // The producer tracks space through level; a push into a full buffer is refused.
    assign out_valid = (cnt != 2'd0);
    assign out_data  = head;
    assign level     = cnt;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((cnt != 2'd2) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= in_data;
                    else             tail <= in_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/rgb_col_streamer.sv
// Reads an RGB image from three channel memories and streams 3-row columns to the conv layer.
module rgb_col_streamer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int IMG_W         = 224,
    parameter int IMG_H         = 224,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int WEIGHT_CYCLES = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rd_addr_0,
    output logic [ADDR_W-1:0]     rd_addr_1,
    output logic [ADDR_W-1:0]     rd_addr_2,
    input  logic [DATA_WIDTH-1:0] rd_r_0,
    input  logic [DATA_WIDTH-1:0] rd_r_1,
    input  logic [DATA_WIDTH-1:0] rd_r_2,
    input  logic [DATA_WIDTH-1:0] rd_g_0,
    input  logic [DATA_WIDTH-1:0] rd_g_1,
    input  logic [DATA_WIDTH-1:0] rd_g_2,
    input  logic [DATA_WIDTH-1:0] rd_b_0,
    input  logic [DATA_WIDTH-1:0] rd_b_1,
    input  logic [DATA_WIDTH-1:0] rd_b_2,
    rgb_col_streamer_if.master    col,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int WW = $clog2(WEIGHT_CYCLES + 1);
    localparam int BW = 9 * DATA_WIDTH;

    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_addr_check
        $error("IMG_W*IMG_H does not fit in the ADDR_W address space");
    end
    if (DATA_WIDTH != DEF_DATA_WIDTH) begin : g_width_check
        $error("DATA_WIDTH must match the conv_pkg column packing width");
    end
    if (IMG_H < 3 || IMG_W < 1 || WEIGHT_CYCLES < 1) begin : g_geom_check
        $error("image must have at least 3 rows and WEIGHT_CYCLES must be at least 1");
    end

    logic [2:0]      state;
    logic [2:0]      state_n;
    logic [WW-1:0]   wcnt;
    logic [RW-1:0]   row_cnt;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_nxt;
    logic [CW-1:0]   col_nxt;
    logic            all_issued;
    logic            inflight;
    logic            frame_start;
    logic            last_read;
    logic            issue;
    logic            pop;
    logic            last_beat;
    logic [1:0]      level;
    logic [2:0]      occ;
    logic            head_valid;
    logic [BW-1:0]   head_data;
    col_beat_t       push_beat;
    col_beat_t       head_beat;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] r,
                                                  input logic [ADDR_W-1:0] c);
        return r * ADDR_W'(IMG_W) + c;
    endfunction

    always_comb begin
        frame_start = start && (state == ST_IDLE || state == ST_DONE);
        pop         = head_valid && col.out_ready;
        // Slots already spoken for once this cycle's pop and the read in flight settle.
        occ         = 3'(level) + 3'(inflight) - 3'(pop);
        last_read   = (row_cnt == RW'(IMG_H - 3)) && (col_cnt == CW'(IMG_W - 1));
        issue       = (state == ST_PRIME || state == ST_STREAM) && !all_issued && (occ < 3'd2);
        last_beat   = pop && all_issued && !inflight && (level == 2'd1);
        if (col_cnt == CW'(IMG_W - 1)) begin
            col_nxt = '0;
            row_nxt = row_cnt + 1'b1;
        end else begin
            col_nxt = col_cnt + 1'b1;
            row_nxt = row_cnt;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:   if (start) state_n = ST_LOAD_W;
            ST_LOAD_W: if (wcnt == WW'(WEIGHT_CYCLES - 1)) state_n = ST_PRIME;
            ST_PRIME:  state_n = ST_STREAM;
            ST_STREAM: if (last_beat) state_n = ST_DONE;
            ST_DONE:   if (start) state_n = ST_LOAD_W;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            all_issued <= 1'b0;
            inflight   <= 1'b0;
            rd_addr_0  <= '0;
            rd_addr_1  <= '0;
            rd_addr_2  <= '0;
        end else begin
            state    <= state_n;
            inflight <= issue;
            if (frame_start) begin
                wcnt       <= '0;
                row_cnt    <= '0;
                col_cnt    <= '0;
                all_issued <= 1'b0;
                rd_addr_0  <= addr_of(ADDR_W'(0), '0);
                rd_addr_1  <= addr_of(ADDR_W'(1), '0);
                rd_addr_2  <= addr_of(ADDR_W'(2), '0);
            end else if (state == ST_LOAD_W) begin
                wcnt <= wcnt + 1'b1;
            end
            // Without an issue the address holds, so the memory simply re-reads it.
            if (issue) begin
                if (last_read) begin
                    all_issued <= 1'b1;
                end else begin
                    row_cnt   <= row_nxt;
                    col_cnt   <= col_nxt;
                    rd_addr_0 <= addr_of(ADDR_W'(row_nxt),             ADDR_W'(col_nxt));
                    rd_addr_1 <= addr_of(ADDR_W'(row_nxt) + ADDR_W'(1), ADDR_W'(col_nxt));
                    rd_addr_2 <= addr_of(ADDR_W'(row_nxt) + ADDR_W'(2), ADDR_W'(col_nxt));
                end
            end
        end
    end

    always_comb begin
        push_beat.r = pack_col(rd_r_0, rd_r_1, rd_r_2);
        push_beat.g = pack_col(rd_g_0, rd_g_1, rd_g_2);
        push_beat.b = pack_col(rd_b_0, rd_b_1, rd_b_2);
        head_beat   = col_beat_t'(head_data);
    end

    col_skid_buf #(.WIDTH(BW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight),
        .in_data   (BW'(push_beat)),
        .out_valid (head_valid),
        .out_data  (head_data),
        .out_ready (col.out_ready),
        .level     (level)
    );

    assign col.load_weight = (state == ST_LOAD_W);
    assign col.input_valid = head_valid;
    assign col.input_col_r = head_beat.r;
    assign col.input_col_g = head_beat.g;
    assign col.input_col_b = head_beat.b;
    assign busy            = (state == ST_LOAD_W) || (state == ST_PRIME) || (state == ST_STREAM);
    assign done            = (state == ST_DONE);
    assign dbg_state       = state;

endmodule

// File: tb/tb_rgb_col_streamer.sv
// Directed frames with randomized images and backpressure against a raster-order column model.
module tb_rgb_col_streamer;
    import conv_pkg::*;

    localparam int DW     = 8;
    localparam int AW     = 18;
    localparam int IW     = 4;
    localparam int IH     = 4;
    localparam int WC     = 2;
    localparam int NPIX   = IW * IH;
    localparam int NBEATS = (IH - 2) * IW;
    localparam int BW     = 9 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr_0, rd_addr_1, rd_addr_2;
    logic [DW-1:0] rd_r_0, rd_r_1, rd_r_2;
    logic [DW-1:0] rd_g_0, rd_g_1, rd_g_2;
    logic [DW-1:0] rd_b_0, rd_b_1, rd_b_2;
    logic          busy, done;
    logic [2:0]    dbg_state;

    logic [DW-1:0] img [3][NPIX];
    logic [BW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    rgb_col_streamer_if #(.DATA_WIDTH(DW)) col_bus ();

    rgb_col_streamer #(
        .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .WEIGHT_CYCLES(WC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_r_0(rd_r_0), .rd_r_1(rd_r_1), .rd_r_2(rd_r_2),
        .rd_g_0(rd_g_0), .rd_g_1(rd_g_1), .rd_g_2(rd_g_2),
        .rd_b_0(rd_b_0), .rd_b_1(rd_b_1), .rd_b_2(rd_b_2),
        .col(col_bus),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // channel memories, one-cycle synchronous read; out-of-range reads return X
    function automatic logic [DW-1:0] rd_mem(input int ch, input logic [AW-1:0] a);
        if (a < AW'(NPIX)) return img[ch][int'(a)];
        return 'x;
    endfunction

    always @(posedge clk) begin
        rd_r_0 <= rd_mem(0, rd_addr_0); rd_r_1 <= rd_mem(0, rd_addr_1); rd_r_2 <= rd_mem(0, rd_addr_2);
        rd_g_0 <= rd_mem(1, rd_addr_0); rd_g_1 <= rd_mem(1, rd_addr_1); rd_g_2 <= rd_mem(1, rd_addr_2);
        rd_b_0 <= rd_mem(2, rd_addr_0); rd_b_1 <= rd_mem(2, rd_addr_1); rd_b_2 <= rd_mem(2, rd_addr_2);
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " load_weight"}, col_bus.load_weight, 0);
        check({tag, " input_valid"}, col_bus.input_valid, 0);
        check({tag, " col_r"}, col_bus.input_col_r, 0);
        check({tag, " col_g"}, col_bus.input_col_g, 0);
        check({tag, " col_b"}, col_bus.input_col_b, 0);
        check({tag, " rd_addr"}, {rd_addr_0, rd_addr_1, rd_addr_2}, 0);
    endtask

    task automatic fill_pattern();
        for (int ch = 0; ch < 3; ch++)
            for (int a = 0; a < NPIX; a++) img[ch][a] = DW'(a + 16 * ch);
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 3; ch++)
            for (int a = 0; a < NPIX; a++) img[ch][a] = DW'($urandom_range(0, 255));
    endtask

    // reference model: one column per (band, x) in raster order, rows top-to-bottom MSB first
    task automatic build_expected();
        logic [BW-1:0] beat;
        exp_q.delete();
        for (int r = 0; r <= IH - 3; r++) begin
            for (int c = 0; c < IW; c++) begin
                beat = '0;
                for (int ch = 0; ch < 3; ch++)
                    for (int k = 0; k < 3; k++)
                        beat[BW - 1 - (ch * 3 + k) * DW -: DW] = img[ch][(r + k) * IW + c];
                exp_q.push_back(beat);
            end
        end
    endtask

    // scoreboard-driven frame: start pulse, then cycle-by-cycle handshake until done or abort
    task automatic run_frame(input string name, input int ready_pct, input int stall_beat,
                             input int spur_beat, input int abort_after);
        int cyc = 0, beats = 0, lw_cycles = 0, last_lw = -100, first_valid = -1;
        int last_acc = 0, stall_left = 0;
        bit overlap = 0, stalled = 0, spur_done = 0, prev_hold = 0, finished = 0, aborted = 0;
        bit ready;
        logic [BW-1:0] prev_beat = '0, got;
        build_expected();
        @(posedge clk); #1;
        start = 1'b1;
        col_bus.out_ready = 1'b0;
        for (int budget = 0; budget < 400 && !finished; budget++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == 1) begin
                check({name, " done_cleared"}, done, 0);
                check({name, " load_weight_first"}, col_bus.load_weight, 1);
            end
            if (col_bus.load_weight) begin
                lw_cycles++;
                last_lw = cyc;
                if (col_bus.input_valid) overlap = 1;
            end
            if (col_bus.input_valid && first_valid < 0) first_valid = cyc;
            got = {col_bus.input_col_r, col_bus.input_col_g, col_bus.input_col_b};
            if (prev_hold) begin
                check({name, " hold_valid"}, col_bus.input_valid, 1);
                check({name, " hold_data"}, got, prev_beat);
            end
            if (stall_left > 0) begin
                ready = 0;
                stall_left--;
            end else if (col_bus.input_valid && beats == stall_beat && !stalled) begin
                stalled = 1;
                ready = 0;
                stall_left = 2;
                check({name, " stall_col_r"}, col_bus.input_col_r, exp_q[0][BW-1 -: 3*DW]);
            end else begin
                ready = ($urandom_range(0, 99) < ready_pct);
            end
            col_bus.out_ready = ready;
            if (col_bus.input_valid && beats == spur_beat && !spur_done) begin
                start = 1'b1;
                spur_done = 1;
            end
            prev_hold = col_bus.input_valid && !ready;
            prev_beat = got;
            if (col_bus.input_valid && ready) begin
                check({name, " beat"}, got, exp_q.pop_front());
                beats++;
                last_acc = cyc;
                if (beats == abort_after) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                    col_bus.out_ready = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check_idle({name, " async_reset"});
                    repeat (2) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                    check_idle({name, " after_reset"});
                    aborted = 1;
                    finished = 1;
                end else if (beats == NBEATS) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                    col_bus.out_ready = 1'b0;
                    check({name, " done_after_last"}, done, 1);
                    check({name, " valid_dropped"}, col_bus.input_valid, 0);
                    check({name, " busy_dropped"}, busy, 0);
                    finished = 1;
                end
            end
        end
        check({name, " finished_in_budget"}, finished, 1);
        if (!aborted) begin
            check({name, " load_weight_cycles"}, lw_cycles, WC);
            check({name, " first_valid_latency"}, first_valid - last_lw, 3);
            check({name, " no_valid_in_load_w"}, overlap, 0);
            check({name, " beat_count"}, beats, NBEATS);
            check({name, " queue_drained"}, exp_q.size(), 0);
            if (ready_pct == 100 && stall_beat < 0)
                check({name, " back_to_back"}, last_acc - first_valid, NBEATS - 1);
        end
    endtask

    initial begin
        col_bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("reset_release");

        fill_pattern();
        run_frame("basic", 100, -1, -1, -1);
        run_frame("stall_restart", 100, 2, 5, -1);
        fill_random();
        run_frame("abort", 60, -1, -1, 4);
        fill_pattern();
        run_frame("after_abort", 100, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            fill_random();
            run_frame("random", $urandom_range(30, 100), $urandom_range(0, NBEATS - 1), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
